// File: rtl/uart_tx_fifo_feeder.sv
// Circular byte FIFO feeding a UART transmitter, launching one word per frame paced by TX_BUSY.
// Optional UART_TX_FIFO_LEVEL_EN adds the FIFO_LEVEL occupancy output.
module uart_tx_fifo_feeder #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] WR_DATA,
    input  logic                  WR_VALID,
    output logic                  WR_READY,
    output logic [DATA_WIDTH-1:0] TX_P_DATA,
    output logic                  TX_DATA_VALID,
    input  logic                  TX_BUSY,
    output logic                  FIFO_EMPTY,
    output logic                  FIFO_FULL
`ifdef UART_TX_FIFO_LEVEL_EN
    ,
    output logic [ADDR_WIDTH:0]   FIFO_LEVEL
`endif
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t                  state, state_next;
    logic                    wait_cnt, wait_cnt_next;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [ADDR_WIDTH-1:0]   wr_ptr, rd_ptr;
    logic [ADDR_WIDTH:0]     count, count_next;
    logic                    wr_en, rd_en;

    assign WR_READY = !FIFO_FULL;
    assign wr_en    = WR_VALID && !FIFO_FULL;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            wait_cnt <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    // A launch that never raises TX_BUSY within two cycles is dropped, not retried.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        rd_en         = 1'b0;
        case (state)
            IDLE: begin
                if (!FIFO_EMPTY && !TX_BUSY) begin
                    rd_en      = 1'b1;
                    state_next = LAUNCH;
                end
            end
            LAUNCH: begin
                wait_cnt_next = 1'b0;
                state_next    = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (TX_BUSY) begin
                    state_next = WAIT_DONE;
                end else if (wait_cnt) begin
                    state_next = IDLE;
                end else begin
                    wait_cnt_next = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!TX_BUSY) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        count_next = count + (ADDR_WIDTH+1)'(wr_en) - (ADDR_WIDTH+1)'(rd_en);
    end

    // Storage is intentionally left out of reset.
    always_ff @(posedge CLK) begin
        if (wr_en) mem[wr_ptr] <= WR_DATA;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            FIFO_EMPTY    <= 1'b1;
            FIFO_FULL     <= 1'b0;
            TX_DATA_VALID <= 1'b0;
            TX_P_DATA     <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            if (rd_en) begin
                rd_ptr    <= rd_ptr + ADDR_WIDTH'(1);
                TX_P_DATA <= mem[rd_ptr];
            end
            TX_DATA_VALID <= rd_en;
            count         <= count_next;
            FIFO_EMPTY    <= (count_next == '0);
            FIFO_FULL     <= (count_next == FULL_COUNT);
        end
    end

`ifdef UART_TX_FIFO_LEVEL_EN
    assign FIFO_LEVEL = count;
`endif

endmodule

// File: tb/tb_uart_tx_fifo_feeder.sv
// Self-checking bench for uart_tx_fifo_feeder: vector table, scoreboard of launched words,
// and a simple transmitter model that holds TX_BUSY for a fixed number of cycles per frame.
module tb_uart_tx_fifo_feeder;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 3;

    logic          CLK = 1'b0;
    logic          RST;
    logic [DW-1:0] WR_DATA;
    logic          WR_VALID;
    logic          WR_READY;
    logic [DW-1:0] TX_P_DATA;
    logic          TX_DATA_VALID;
    logic          TX_BUSY;
    logic          FIFO_EMPTY;
    logic          FIFO_FULL;
`ifdef UART_TX_FIFO_LEVEL_EN
    logic [AW:0]   FIFO_LEVEL;
`endif

    always #5 CLK = ~CLK;

    uart_tx_fifo_feeder #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .WR_DATA      (WR_DATA),
        .WR_VALID     (WR_VALID),
        .WR_READY     (WR_READY),
        .TX_P_DATA    (TX_P_DATA),
        .TX_DATA_VALID(TX_DATA_VALID),
        .TX_BUSY      (TX_BUSY),
        .FIFO_EMPTY   (FIFO_EMPTY),
        .FIFO_FULL    (FIFO_FULL)
`ifdef UART_TX_FIFO_LEVEL_EN
        ,
        .FIFO_LEVEL   (FIFO_LEVEL)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", name, act, exp);
        end
    endtask

    // Transmitter model: Busy rises the half-cycle after a launch is seen and lasts busy_len cycles.
    logic          busy_force = 1'b0;
    logic          tx_auto    = 1'b1;
    int unsigned   busy_len   = 10;
    int unsigned   model_cnt  = 0;
    assign TX_BUSY = busy_force | (model_cnt != 0);

    logic [DW-1:0] exp_q[$];
    int unsigned   cyc = 0;
    int unsigned   launches = 0;
    int unsigned   last_launch = 0;
    int unsigned   prev_launch = 0;
    logic          prev_valid = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (RST) model_cnt = 0;
        else if (model_cnt != 0) model_cnt = model_cnt - 1;
        if (TX_DATA_VALID) begin
            launches++;
            prev_launch = last_launch;
            last_launch = cyc;
            check("valid_one_cycle", 32'(prev_valid), 32'd0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_launch: got data=0x%0h want no launch", TX_P_DATA);
            end else begin
                check("launch_data", 32'(TX_P_DATA), 32'(exp_q.pop_front()));
            end
            if (tx_auto && !RST) model_cnt = busy_len;
        end
        prev_valid = TX_DATA_VALID;
    end

    task automatic write_stream(input logic [DW-1:0] d);
        WR_DATA  = d;
        WR_VALID = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(negedge CLK);
            if (WR_READY) begin
                exp_q.push_back(d);
                @(posedge CLK);
                #1;
                WR_VALID = 1'b0;
                return;
            end
        end
        check("write_timeout", 32'd0, 32'd1);
        WR_VALID = 1'b0;
    endtask

    task automatic wait_drain(input int unsigned max_cycles);
        logic done;
        done = 1'b0;
        for (int unsigned i = 0; i < max_cycles && !done; i++) begin
            @(negedge CLK);
            if (exp_q.size() == 0 && model_cnt == 0 && !TX_BUSY) done = 1'b1;
        end
        repeat (4) @(negedge CLK);
        check("drain_done", 32'(done), 32'd1);
        @(posedge CLK);
        #1;
    endtask

    typedef struct {
        logic [DW-1:0] d;
        logic          v;
        logic          b;
        logic          acc;
        logic          e_ready;
        logic          e_empty;
        logic          e_full;
        logic          e_valid;
    } vec_t;

    vec_t        vecs[9];
    int unsigned base;

    initial begin
        vecs[0] = '{8'h01, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'h02, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{8'h03, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{8'h04, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{8'h05, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{8'h06, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{8'h07, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{8'h08, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[8] = '{8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        RST      = 1'b0;
        WR_VALID = 1'b0;
        WR_DATA  = '0;
        #2 RST = 1'b1;
        #2;
        check("rst_ready", 32'(WR_READY), 32'd1);
        check("rst_empty", 32'(FIFO_EMPTY), 32'd1);
        check("rst_full", 32'(FIFO_FULL), 32'd0);
        check("rst_valid", 32'(TX_DATA_VALID), 32'd0);
        check("rst_pdata", 32'(TX_P_DATA), 32'd0);
`ifdef UART_TX_FIFO_LEVEL_EN
        check("rst_level", 32'(FIFO_LEVEL), 32'd0);
`endif
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;

        // Single word into an idle feeder: launch appears on the edge after the write.
        WR_DATA  = 8'hA5;
        WR_VALID = 1'b1;
        exp_q.push_back(8'hA5);
        @(posedge CLK);
        #1 WR_VALID = 1'b0;
        @(negedge CLK);
        check("t1_valid_early", 32'(TX_DATA_VALID), 32'd0);
        check("t1_empty_after_write", 32'(FIFO_EMPTY), 32'd0);
        @(negedge CLK);
        check("t1_valid", 32'(TX_DATA_VALID), 32'd1);
        check("t1_pdata", 32'(TX_P_DATA), 32'hA5);
        check("t1_empty_after_launch", 32'(FIFO_EMPTY), 32'd1);
        @(negedge CLK);
        check("t1_valid_drop", 32'(TX_DATA_VALID), 32'd0);
        check("t1_pdata_hold", 32'(TX_P_DATA), 32'hA5);
        wait_drain(200);

        // Fill to full with Busy held, ninth write dropped.
        for (int i = 0; i < 9; i++) begin
            WR_DATA    = vecs[i].d;
            WR_VALID   = vecs[i].v;
            busy_force = vecs[i].b;
            if (vecs[i].acc) exp_q.push_back(vecs[i].d);
            @(posedge CLK);
            @(negedge CLK);
            check($sformatf("t2_ready[%0d]", i), 32'(WR_READY), 32'(vecs[i].e_ready));
            check($sformatf("t2_empty[%0d]", i), 32'(FIFO_EMPTY), 32'(vecs[i].e_empty));
            check($sformatf("t2_full[%0d]", i), 32'(FIFO_FULL), 32'(vecs[i].e_full));
            check($sformatf("t2_valid[%0d]", i), 32'(TX_DATA_VALID), 32'(vecs[i].e_valid));
        end
        WR_VALID   = 1'b0;
        busy_force = 1'b0;
        wait_drain(2000);
        check("t2_empty_end", 32'(FIFO_EMPTY), 32'd1);

        // Twenty words against a 10-cycle Busy; pointers wrap.
        base = launches;
        for (int i = 0; i < 20; i++) write_stream(8'(i * 13 + 5));
        wait_drain(3000);
        check("t3_launch_count", launches - base, 32'd20);
        check("t3_empty_end", 32'(FIFO_EMPTY), 32'd1);

        // Full FIFO: write presented on the launch edge is refused, next one accepted.
        busy_force = 1'b1;
        for (int i = 0; i < 8; i++) write_stream(8'h40 + 8'(i));
        check("t4_full", 32'(FIFO_FULL), 32'd1);
        busy_force = 1'b0;
        WR_DATA    = 8'h77;
        WR_VALID   = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        check("t4_launch", 32'(TX_DATA_VALID), 32'd1);
        check("t4_full_after_launch", 32'(FIFO_FULL), 32'd0);
        check("t4_ready_after_launch", 32'(WR_READY), 32'd1);
`ifdef UART_TX_FIFO_LEVEL_EN
        check("t4_level7", 32'(FIFO_LEVEL), 32'd7);
`endif
        WR_DATA = 8'h78;
        exp_q.push_back(8'h78);
        @(posedge CLK);
        @(negedge CLK);
        check("t4_full_again", 32'(FIFO_FULL), 32'd1);
`ifdef UART_TX_FIFO_LEVEL_EN
        check("t4_level8", 32'(FIFO_LEVEL), 32'd8);
`endif
        WR_VALID = 1'b0;
        wait_drain(2000);

        // Transmitter never asserts Busy: each launch times out, then the next word goes.
        tx_auto = 1'b0;
        write_stream(8'hC1);
        write_stream(8'hC2);
        wait_drain(200);
        check("t7_gap", last_launch - prev_launch, 32'd4);
        check("t7_empty_end", 32'(FIFO_EMPTY), 32'd1);
        tx_auto = 1'b1;

        // Reset while in WAIT_DONE with three words still queued.
        busy_force = 1'b1;
        for (int i = 0; i < 4; i++) write_stream(8'h91 + 8'(i));
        busy_force = 1'b0;
        repeat (5) @(posedge CLK);
        #1 RST = 1'b1;
        #1;
        check("t5_empty", 32'(FIFO_EMPTY), 32'd1);
        check("t5_valid", 32'(TX_DATA_VALID), 32'd0);
        check("t5_full", 32'(FIFO_FULL), 32'd0);
        check("t5_ready", 32'(WR_READY), 32'd1);
        check("t5_flushed", 32'(exp_q.size()), 32'd3);
        exp_q.delete();
        base = launches;
        @(posedge CLK);
        #1 RST = 1'b0;
        repeat (30) @(negedge CLK);
        check("t5_no_launch", launches - base, 32'd0);
        @(posedge CLK);
        #1;

        // Occupancy across three writes and one launch.
        busy_force = 1'b1;
        WR_DATA    = 8'hD1;
        WR_VALID   = 1'b1;
        exp_q.push_back(8'hD1);
        @(posedge CLK);
        #1 WR_DATA = 8'hD2;
        exp_q.push_back(8'hD2);
        @(negedge CLK);
`ifdef UART_TX_FIFO_LEVEL_EN
        check("t6_level1", 32'(FIFO_LEVEL), 32'd1);
`else
        check("t6_nonempty1", 32'(FIFO_EMPTY), 32'd0);
`endif
        @(posedge CLK);
        #1 WR_DATA = 8'hD3;
        exp_q.push_back(8'hD3);
        @(negedge CLK);
`ifdef UART_TX_FIFO_LEVEL_EN
        check("t6_level2", 32'(FIFO_LEVEL), 32'd2);
`endif
        @(posedge CLK);
        #1;
        WR_VALID   = 1'b0;
        busy_force = 1'b0;
        @(negedge CLK);
`ifdef UART_TX_FIFO_LEVEL_EN
        check("t6_level3", 32'(FIFO_LEVEL), 32'd3);
`endif
        @(posedge CLK);
        @(negedge CLK);
        check("t6_launch", 32'(TX_DATA_VALID), 32'd1);
`ifdef UART_TX_FIFO_LEVEL_EN
        check("t6_level_after_launch", 32'(FIFO_LEVEL), 32'd2);
`endif
        wait_drain(2000);
        check("final_empty", 32'(FIFO_EMPTY), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
